// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 active-low keypad scanner with per-key debounce and a queued valid/ready event stream.
// Define KEYPAD_RELEASE_EVT_EN to queue release events too; by default only presses are queued.
module keypad_scan_ctrl #(
    parameter int F_CLK      = 50000000,
    parameter int F_SCAN     = 1000,
    parameter int DEB_SCANS  = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic        evt_press,
    output logic [15:0] key_held,
    output logic        overflow
);
    localparam int DIV = F_CLK / F_SCAN;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(DEB_SCANS);
    localparam int AW  = $clog2(FIFO_DEPTH);

    logic [3:0]    sync1, sync2, raw;
    logic [PW-1:0] pre;
    logic          tick;
    logic [1:0]    row;
    logic [CW-1:0] cnt [16];
    logic [15:0]   sampled, differ, chg, flag, pending, clr;
    logic [3:0]    sel;
    logic          push, pop, full, empty, push_press;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [4:0]    mem [FIFO_DEPTH];

    assign raw   = ~sync2;
    assign tick  = pre == PW'(DIV - 1);
    assign row_n = ~(4'b0001 << row);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            pre   <= '0;
            row   <= '0;
        end else begin
            sync1 <= col_n;
            sync2 <= sync1;
            pre   <= tick ? '0 : pre + 1'b1;
            if (tick) row <= row + 1'b1;
        end
    end

    always_comb begin
        sampled = '0;
        differ  = '0;
        chg     = '0;
        for (int k = 0; k < 16; k++) begin
            sampled[k] = tick && (row == 2'(k / 4));
            differ[k]  = raw[k % 4] != key_held[k];
            chg[k]     = sampled[k] && differ[k] && (cnt[k] == CW'(DEB_SCANS - 1));
        end
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    assign flag       = chg;
    assign push_press = key_held[sel];
`else
    assign flag       = chg & ~key_held;
    assign push_press = 1'b1;
`endif

    // A change flagged while the key's previous event is still pending is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_held <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < 16; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 16; k++)
                if (sampled[k]) cnt[k] <= (differ[k] && !chg[k]) ? cnt[k] + 1'b1 : '0;
            key_held <= key_held ^ chg;
            pending  <= (pending & ~clr) | flag;
            if (|(pending & flag)) overflow <= 1'b1;
        end
    end

    always_comb begin
        sel = '0;
        for (int k = 15; k >= 0; k--)
            if (pending[k]) sel = 4'(k);
    end

    assign push      = |pending && !full;
    assign clr       = push ? (16'(1) << sel) : '0;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign evt_code  = mem[rd_ptr[AW-1:0]][4:1];
    assign evt_press = mem[rd_ptr[AW-1:0]][0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {sel, push_press};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule
